// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage (PC register, fetch FSM, instruction buffer).
// FETCH_MISALIGN_TRAP_EN adds a misalign flag to every buffered entry.
package fetch_pkg;

  typedef enum logic [1:0] {REQ, WAIT, DRAIN} fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign;
`endif
  } ibuf_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/response and decode-side handshake of the fetch stage.
// FETCH_MISALIGN_TRAP_EN adds if_misalign_o.
interface fetch_pc_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic        if_ready_i;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        if_misalign_o;
`endif

  modport master (
`ifdef FETCH_MISALIGN_TRAP_EN
    output if_misalign_o,
`endif
    output imem_req_o, imem_addr_o, if_valid_o, if_instr_o, if_pc_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, if_ready_i
  );

  modport slave (
`ifdef FETCH_MISALIGN_TRAP_EN
    input  if_misalign_o,
`endif
    input  imem_req_o, imem_addr_o, if_valid_o, if_instr_o, if_pc_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, if_ready_i
  );
endinterface

// File: rtl/fetch_ibuf.sv
// Synchronous instruction-buffer FIFO with flush, count and full/empty flags.
// A write in the flush cycle lands as the sole entry of the emptied buffer.
module fetch_ibuf
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  ibuf_entry_t              wr_data,
  input  logic                     rd_en,
  output ibuf_entry_t              rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  ibuf_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wa;
  logic          push, pop, we;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop     = rd_en & ~empty;
  assign push    = wr_en & (~full | pop);
  assign we      = flush ? wr_en : push;
  assign wa      = flush ? '0 : wr_ptr;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk)
    if (we) mem[wa] <= wr_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= wr_en ? AW'(1) : '0;
      count  <= wr_en ? (AW+1)'(1) : '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC register and single-outstanding instruction fetch into a small decode buffer.
// FETCH_MISALIGN_TRAP_EN: misaligned redirects enqueue a flagged NOP and stall fetch.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IBUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  output logic [31:0]        pc_plus4_o,
  fetch_pc_unit_if.master    bus
);
  localparam int CW = $clog2(IBUF_DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, req_pc_q;
  logic [CW-1:0] ibuf_count;
  logic          ibuf_full, ibuf_empty, ibuf_wr;
  ibuf_entry_t   ibuf_wdata, ibuf_head;
  logic          outstanding, room, issue, req, fire, rsp_wr, stall_gate;

  assign outstanding = (state_q != REQ);
  // Buffer slots already promised: stored entries plus the in-flight response.
  assign room = ({1'b0, ibuf_count} + {{CW{1'b0}}, outstanding}) < (CW+1)'(IBUF_DEPTH);

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      REQ:     issue = 1'b1;
      WAIT:    issue = bus.imem_rvalid_i;
      default: issue = 1'b0;
    endcase
    issue = issue & room & ~ibuf_full & ~redirect_i & ~stall_gate;
    req   = rst_n & issue;
    fire  = req & bus.imem_gnt_i;
    case (state_q)
      REQ:     if (fire) state_d = WAIT;
      WAIT:    if (bus.imem_rvalid_i) state_d = fire ? WAIT : REQ;
      DRAIN:   if (bus.imem_rvalid_i) state_d = REQ;
      default: state_d = REQ;
    endcase
    if (redirect_i)
      state_d = ((outstanding & ~bus.imem_rvalid_i) | fire) ? DRAIN : REQ;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (redirect_i)  fetch_pc_q <= redirect_pc_i;
      else if (fire)   fetch_pc_q <= fetch_pc_q + PC_STEP;
      if (fire)        req_pc_q   <= fetch_pc_q;
    end
  end

  assign rsp_wr = (state_q == WAIT) & bus.imem_rvalid_i & ~redirect_i;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic stall_q, trap_wr;

  // Fetch stays parked after a misaligned redirect until the next redirect.
  always_ff @(posedge clk) begin
    if (!rst_n)          stall_q <= 1'b0;
    else if (redirect_i) stall_q <= redirect_pc_i[1];
  end

  assign stall_gate = stall_q;
  assign trap_wr    = redirect_i & redirect_pc_i[1];
  assign ibuf_wr    = rsp_wr | trap_wr;
  assign ibuf_wdata = trap_wr
    ? ibuf_entry_t'{pc: redirect_pc_i, instr: NOP_INSTR, misalign: 1'b1}
    : ibuf_entry_t'{pc: req_pc_q, instr: bus.imem_rdata_i, misalign: 1'b0};
  assign bus.imem_addr_o   = fetch_pc_q;
  assign bus.if_misalign_o = ~ibuf_empty & ibuf_head.misalign;
`else
  assign stall_gate      = 1'b0;
  assign ibuf_wr         = rsp_wr;
  assign ibuf_wdata      = ibuf_entry_t'{pc: req_pc_q, instr: bus.imem_rdata_i};
  assign bus.imem_addr_o = {fetch_pc_q[31:2], 2'b00};
`endif

  fetch_ibuf #(.DEPTH(IBUF_DEPTH)) u_ibuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect_i),
    .wr_en   (ibuf_wr),
    .wr_data (ibuf_wdata),
    .rd_en   (bus.if_ready_i),
    .rd_data (ibuf_head),
    .count   (ibuf_count),
    .full    (ibuf_full),
    .empty   (ibuf_empty)
  );

  assign pc_plus4_o     = fetch_pc_q + PC_STEP;
  assign bus.imem_req_o = req;
  assign bus.if_valid_o = ~ibuf_empty;
  assign bus.if_instr_o = ibuf_empty ? '0 : ibuf_head.instr;
  assign bus.if_pc_o    = ibuf_empty ? '0 : ibuf_head.pc;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: streaming, backpressure, redirect/drain, wrap, misaligned target.
// Memory returns addr ^ 32'h5A5A_0000 one cycle after each grant.
module tb_fetch_pc_unit;
  logic        clk = 1'b0;
  logic        rst_n, redirect;
  logic [31:0] redirect_pc, pc_plus4;
  logic        auto_resp, granted;
  logic [31:0] gaddr;
  int          n_cmp = 0, n_err = 0;

  fetch_pc_unit_if bus ();

  fetch_pc_unit #(.RESET_PC(32'h0000_0100), .IBUF_DEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .pc_plus4_o    (pc_plus4),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: note any grant before the edge, answer it just after the edge.
  task automatic tick();
    @(negedge clk);
    granted = bus.imem_req_o & bus.imem_gnt_i;
    gaddr   = bus.imem_addr_o;
    @(posedge clk);
    #1;
    bus.imem_rvalid_i = granted & auto_resp;
    bus.imem_rdata_i  = mem_word(gaddr);
    #1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && !bus.imem_req_o; i++) tick();
    chk("wait_req", bus.imem_req_o, 1);
  endtask

  // Expects if_ready_i=1: wait for the next head, check it, consume it.
  task automatic pop_expect(input logic [31:0] exp_pc);
    logic [31:0] wa;
    wa = {exp_pc[31:2], 2'b00};
    for (int i = 0; i < 20 && !bus.if_valid_o; i++) tick();
    chk("pop_valid", bus.if_valid_o, 1);
    chk("pop_pc", bus.if_pc_o, exp_pc);
    chk("pop_instr", bus.if_instr_o, mem_word(wa));
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("pop_misalign", bus.if_misalign_o, 0);
`endif
    tick();
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; auto_resp = 1'b1;
    bus.imem_gnt_i = 1'b1; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0;
    bus.if_ready_i = 1'b1;
    tick(); tick();
    chk("rst_req", bus.imem_req_o, 0);
    chk("rst_valid", bus.if_valid_o, 0);
    chk("rst_instr", bus.if_instr_o, 0);
    chk("rst_pc", bus.if_pc_o, 0);
    chk("rst_pc_plus4", pc_plus4, 32'h104);

    // Streaming with gnt=1 and one-cycle response.
    rst_n = 1'b1; #1;
    chk("s_req0", bus.imem_req_o, 1);
    chk("s_addr0", bus.imem_addr_o, 32'h100);
    tick();
    chk("s_addr1", bus.imem_addr_o, 32'h104);
    chk("s_valid_lat", bus.if_valid_o, 0);
    tick();
    chk("s_req_full", bus.imem_req_o, 0);
    pop_expect(32'h100);
    pop_expect(32'h104);
    pop_expect(32'h108);

    // Reset mid-stream, then backpressure fills the buffer.
    rst_n = 1'b0; bus.if_ready_i = 1'b0;
    tick(); tick();
    chk("rst2_valid", bus.if_valid_o, 0);
    rst_n = 1'b1;
    repeat (6) tick();
    chk("bp_valid", bus.if_valid_o, 1);
    chk("bp_req", bus.imem_req_o, 0);
    chk("bp_pc", bus.if_pc_o, 32'h100);
    tick();
    chk("bp_hold_pc", bus.if_pc_o, 32'h100);
    chk("bp_hold_instr", bus.if_instr_o, mem_word(32'h100));
    bus.if_ready_i = 1'b1;
    pop_expect(32'h100);
    pop_expect(32'h104);
    pop_expect(32'h108);
    pop_expect(32'h10C);

    // Redirect with an outstanding request: late response is drained.
    auto_resp = 1'b0;
    wait_req();
    tick();
    redirect = 1'b1; redirect_pc = 32'h200; #1;
    chk("dr_req_forced", bus.imem_req_o, 0);
    tick();
    redirect = 1'b0; #1;
    chk("dr_flushed", bus.if_valid_o, 0);
    chk("dr_pc_plus4", pc_plus4, 32'h204);
    chk("dr_no_req", bus.imem_req_o, 0);
    bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'hDEAD_BEEF; #1;
    chk("dr_rv_no_req", bus.imem_req_o, 0);
    auto_resp = 1'b1;
    tick();
    chk("dr_no_write", bus.if_valid_o, 0);
    chk("dr_req", bus.imem_req_o, 1);
    chk("dr_addr", bus.imem_addr_o, 32'h200);
    pop_expect(32'h200);
    pop_expect(32'h204);

    // Redirect in the same cycle as rvalid: data never presented.
    wait_req();
    tick();
    redirect = 1'b1; redirect_pc = 32'h400; #1;
    chk("rr_req_forced", bus.imem_req_o, 0);
    tick();
    redirect = 1'b0; #1;
    chk("rr_empty", bus.if_valid_o, 0);
    chk("rr_req", bus.imem_req_o, 1);
    chk("rr_addr", bus.imem_addr_o, 32'h400);
    pop_expect(32'h400);
    pop_expect(32'h404);

    // PC wraps modulo 2^32.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0; #1;
    chk("wr_addr", bus.imem_addr_o, 32'hFFFF_FFFC);
    chk("wr_pc_plus4", pc_plus4, 32'h0);
    pop_expect(32'hFFFF_FFFC);
    pop_expect(32'h0);

    // Target with bit 1 set.
    redirect = 1'b1; redirect_pc = 32'h302;
    tick();
    redirect = 1'b0; #1;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("ma_valid", bus.if_valid_o, 1);
    chk("ma_flag", bus.if_misalign_o, 1);
    chk("ma_pc", bus.if_pc_o, 32'h302);
    chk("ma_instr", bus.if_instr_o, 32'h0000_0013);
    for (int i = 0; i < 5; i++) begin
      chk("ma_stall_req", bus.imem_req_o, 0);
      tick();
    end
    redirect = 1'b1; redirect_pc = 32'h500;
    tick();
    redirect = 1'b0; #1;
    pop_expect(32'h500);
`else
    chk("ma_addr", bus.imem_addr_o, 32'h300);
    chk("ma_pc_plus4", pc_plus4, 32'h306);
    pop_expect(32'h302);
    pop_expect(32'h306);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
